// File: rtl/kmc_npr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kmc_npr_pkg
// Purpose  : Shared types and helpers for the KMC11 NPR (DMA) controller:
//            FSM state encoding, default parameter values and the byte-lane
//            selector used on byte DATI cycles.
// Revision : 1.0  initial release
// ============================================================================
package kmc_npr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } npr_state_e;

    localparam int c_TIMEOUT_DEF = 1023;
    localparam int c_ADDR_W_DEF  = 18;

    // Byte read: the addressed byte lands right-justified, upper byte zero.
    function automatic logic [15:0] byte_lane(input logic odd, input logic [15:0] d);
        return {8'h00, (odd ? d[15:8] : d[7:0])};
    endfunction

endpackage
`default_nettype wire

// File: rtl/kmc_npr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : kmc_npr_ctrl_if
// Purpose  : Bundles the microprocessor-side NPR register signals and the
//            Unibus-side bus interface signals of the NPR controller.
// Modports : master - the NPR controller itself
//            slave  - its environment (microcode datapath + bus interface)
// Revision : 1.0  initial release
// ============================================================================
interface kmc_npr_ctrl_if #(
    parameter int ADDR_W = 18
) ();
    // microprocessor side
    logic              kmcINIT;
    logic              kmcNPRGO;
    logic              kmcNPRWR;
    logic              kmcNPRBYTE;
    logic [ADDR_W-1:0] kmcNPRADDR;
    logic [15:0]       kmcNPRDATO;
    logic              kmcNPRACC;
    logic [15:0]       kmcNPRDATI;
    logic              kmcNPRBUSY;
    logic              kmcNPRDONE;
    logic              kmcNPRNXM;
    logic              kmcSTALL;
    // bus side
    logic              devREQO;
    logic              devACKI;
    logic              devCYCO;
    logic              devWRO;
    logic              devBYTEO;
    logic [ADDR_W-1:0] devADDRO;
    logic [15:0]       devDATAO;
    logic [15:0]       devDATAI;
    logic              devDONEI;

    modport master (
        input  kmcINIT, kmcNPRGO, kmcNPRWR, kmcNPRBYTE, kmcNPRADDR, kmcNPRDATO,
               kmcNPRACC, devACKI, devDATAI, devDONEI,
        output kmcNPRDATI, kmcNPRBUSY, kmcNPRDONE, kmcNPRNXM, kmcSTALL,
               devREQO, devCYCO, devWRO, devBYTEO, devADDRO, devDATAO
    );

    modport slave (
        output kmcINIT, kmcNPRGO, kmcNPRWR, kmcNPRBYTE, kmcNPRADDR, kmcNPRDATO,
               kmcNPRACC, devACKI, devDATAI, devDONEI,
        input  kmcNPRDATI, kmcNPRBUSY, kmcNPRDONE, kmcNPRNXM, kmcSTALL,
               devREQO, devCYCO, devWRO, devBYTEO, devADDRO, devDATAO
    );
endinterface
`default_nettype wire

// File: rtl/kmc_npr_timer.sv
`default_nettype none
// ============================================================================
// Module   : kmc_npr_timer
// Purpose  : Bus-cycle watchdog for the NPR transfer phase. Counts enabled
//            cycles from zero and flags the cycle in which the TIMEOUT-th
//            enabled cycle occurs.
// Ports    : clk, rst  - clock, synchronous active-high reset
//            i_clr     - hold count at zero
//            i_en      - count this cycle
//            o_tc      - terminal count (TIMEOUT-th enabled cycle)
// Revision : 1.0  initial release
// ============================================================================
module kmc_npr_timer #(
    parameter int TIMEOUT = 1023
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_tc
);
    localparam int c_CW = $clog2(TIMEOUT + 1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The count shows how many enabled cycles already elapsed, so the
    // TIMEOUT-th one is the cycle in which the count equals TIMEOUT-1.
    assign o_tc = i_en && (r_cnt == c_CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/kmc_npr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : kmc_npr_ctrl
// Purpose  : KMC11 NPR (DMA) transfer sequencer. Latches a request on the
//            microcode GO pulse, performs the bus request/grant handshake,
//            runs one word/byte DATI or DATO cycle and returns read data,
//            a completion pulse and NXM status. Stalls the microprocessor
//            while microcode touches the NPR registers mid-transfer.
// Ports    : clk, rst  - clock, synchronous active-high reset
//            bus       - kmc_npr_ctrl_if.master (microprocessor + bus side)
// Config   : KMC_NPR_TIMEOUT_EN - when defined, a TIMEOUT-cycle watchdog in
//            the transfer phase declares NXM; otherwise the transfer waits
//            forever for slave completion and NXM reads 0.
// Revision : 1.0  initial release
// ============================================================================
module kmc_npr_ctrl
    import kmc_npr_pkg::*;
#(
    parameter int TIMEOUT = c_TIMEOUT_DEF,
    parameter int ADDR_W  = c_ADDR_W_DEF
) (
    input  wire logic       clk,
    input  wire logic       rst,
    kmc_npr_ctrl_if.master  bus
);
    npr_state_e        r_state;
    npr_state_e        w_next;
    logic              w_rst;
    logic              w_go;
    logic              w_xfer;
    logic              w_tc;

    logic [ADDR_W-1:0] r_addr;
    logic              r_wr;
    logic              r_byte;
    logic [15:0]       r_dato;
    logic [15:0]       r_dati;

    // Microprocessor INIT has exactly the effect of the block reset.
    assign w_rst  = rst | bus.kmcINIT;
    // GO is honoured only from IDLE; during a transfer or DONE it is ignored.
    assign w_go   = (r_state == IDLE) && bus.kmcNPRGO;
    assign w_xfer = (r_state == XFER);

`ifdef KMC_NPR_TIMEOUT_EN
    logic r_nxm;

    kmc_npr_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst   (w_rst),
        .i_clr (!w_xfer),
        .i_en  (w_xfer),
        .o_tc  (w_tc)
    );

    // Slave completion takes priority over a coincident timeout.
    always_ff @(posedge clk) begin
        if (w_rst || w_go) begin
            r_nxm <= 1'b0;
        end else if (w_xfer && w_tc && !bus.devDONEI) begin
            r_nxm <= 1'b1;
        end
    end

    assign bus.kmcNPRNXM = r_nxm;
`else
    localparam int c_unused_timeout = TIMEOUT;

    assign w_tc          = 1'b0;
    assign bus.kmcNPRNXM = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.kmcNPRGO) w_next = REQ;
            REQ:     if (bus.devACKI) w_next = XFER;
            XFER:    if (bus.devDONEI || w_tc) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_addr <= '0;
            r_wr   <= 1'b0;
            r_byte <= 1'b0;
            r_dato <= '0;
            r_dati <= '0;
        end else begin
            if (w_go) begin
                r_addr <= bus.kmcNPRADDR;
                r_wr   <= bus.kmcNPRWR;
                r_byte <= bus.kmcNPRBYTE;
                r_dato <= bus.kmcNPRDATO;
            end
            if (w_xfer && bus.devDONEI && !r_wr) begin
                r_dati <= r_byte ? byte_lane(r_addr[0], bus.devDATAI) : bus.devDATAI;
            end
        end
    end

    assign bus.kmcNPRBUSY = (r_state == REQ) || w_xfer;
    assign bus.kmcNPRDONE = (r_state == DONE);
    assign bus.kmcNPRDATI = r_dati;
    assign bus.kmcSTALL   = bus.kmcNPRACC && bus.kmcNPRBUSY;

    // Bus-side qualifiers are only presented while the cycle is active.
    assign bus.devREQO  = (r_state == REQ);
    assign bus.devCYCO  = w_xfer;
    assign bus.devADDRO = w_xfer ? r_addr : '0;
    assign bus.devWRO   = w_xfer && r_wr;
    assign bus.devBYTEO = w_xfer && r_byte;
    // Byte writes replicate the low byte onto both lanes.
    assign bus.devDATAO = !w_xfer ? 16'h0000 :
                          r_byte  ? {r_dato[7:0], r_dato[7:0]} : r_dato;

endmodule
`default_nettype wire

// File: doc/kmc_npr_ctrl.md
Name: kmc_npr_ctrl

Overview:
- Sequences KMC11 non-processor-request (NPR, DMA) transfers between the microprocessor NPR registers and the Unibus-side bus interface.
- Latches a request on a microcode GO pulse and performs the bus request/grant handshake.
- Runs one word or byte DATI/DATO cycle and returns read data, completion and non-existent-memory (NXM) status to the microprocessor datapath.
- Stalls the microprocessor when microcode touches NPR registers mid-transfer.

Parameters:
- TIMEOUT, 1023, bus cycles allowed in XFER before NXM is declared (counter width = $clog2(TIMEOUT+1)).
- ADDR_W, 18, Unibus address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- kmcINIT  in  1  microprocessor initialize; same effect as rst
- kmcNPRGO  in  1  one-cycle start pulse from microcode
- kmcNPRWR  in  1  1 = DATO (write to bus), 0 = DATI (read)
- kmcNPRBYTE  in  1  byte transfer
- kmcNPRADDR  in  ADDR_W  transfer address
- kmcNPRDATO  in  16  write data
- kmcNPRACC  in  1  microcode access to NPR registers this cycle
- kmcNPRDATI  out  16  read data
- kmcNPRBUSY  out  1  transfer in progress
- kmcNPRDONE  out  1  one-cycle completion pulse
- kmcNPRNXM  out  1  sticky NXM flag, cleared by next GO
- kmcSTALL  out  1  microprocessor clock-enable hold
- devREQO  out  1  NPR bus request
- devACKI  in  1  bus grant
- devCYCO  out  1  bus cycle active
- devWRO  out  1  cycle is DATO
- devBYTEO  out  1  byte cycle
- devADDRO  out  ADDR_W  latched address
- devDATAO  out  16  write data
- devDATAI  in  16  read data
- devDONEI  in  1  slave completion

Behaviour:
- Reset (rst or kmcINIT, any state): state forced to IDLE. All outputs 0, including latches, kmcNPRDATI and kmcNPRNXM.
- States: IDLE, REQ, XFER, DONE.
- IDLE:
  - On kmcNPRGO: latch ADDR, WR, BYTE and DATO; clear NXM; set BUSY next cycle; go to REQ.
  - Without GO: stay in IDLE.
- REQ:
  - devREQO=1 until devACKI is sampled high, then go to XFER.
  - devREQO deasserts in the cycle XFER is entered.
- XFER:
  - devCYCO=1; devADDRO, devWRO and devBYTEO are driven from the latches.
  - On devDONEI: for a read, capture data into kmcNPRDATI; go to DONE.
  - Timeout counter loads 0 on XFER entry and increments each XFER cycle. When it reaches TIMEOUT with no devDONEI: set kmcNPRNXM, leave kmcNPRDATI unchanged, go to DONE.
  - devDONEI and timeout in the same cycle: devDONEI wins and NXM is not set.
- DONE:
  - kmcNPRDONE=1 for exactly one cycle; devCYCO=0; go to IDLE.
  - BUSY clears on entry to DONE, so kmcNPRDONE and BUSY=0 coincide.
- kmcNPRBUSY=1 in REQ and XFER only.
- Minimum latency from GO to DONE pulse: 3 cycles (GO, REQ with immediate ACK, XFER with immediate DONEI, DONE).
- GO while BUSY or in DONE is ignored; latches and state are unchanged.
- kmcSTALL = kmcNPRACC & kmcNPRBUSY (combinational). The stall releases in the DONE cycle.
- Byte DATI: kmcNPRDATI[7:0] = ADDR[0] ? devDATAI[15:8] : devDATAI[7:0], and kmcNPRDATI[15:8] = 0.
- Byte DATO: devDATAO = {DATO[7:0], DATO[7:0]}.
- Word transfers: ADDR[0] is passed through unchanged; there is no alignment check.
- devACKI outside REQ and devDONEI outside XFER are ignored.

Optional Feature:
- KMC_NPR_TIMEOUT_EN defined: timeout counter and NXM behaviour as above.
- KMC_NPR_TIMEOUT_EN undefined: no counter; XFER waits indefinitely for devDONEI; kmcNPRNXM tied 0; the TIMEOUT parameter is unused.

Decomposition:
- Package kmc_npr_pkg holds:
  - state enum (IDLE, REQ, XFER, DONE), 2 bits;
  - default TIMEOUT constant;
  - byte-lane select function.
- Sub-module kmc_npr_timer: clear/enable/terminal-count counter, instantiated only under KMC_NPR_TIMEOUT_EN.

Test Plan:
- Word DATI: GO with ADDR=0o001000, WR=0; ACK after 2 cycles; DONEI after 3 cycles with DATAI=16'h1234 -> kmcNPRDATI=16'h1234, one DONE pulse, NXM=0, BUSY high exactly during REQ/XFER.
- Byte DATO odd: ADDR=0o001001, BYTE=1, DATO=16'hxxA5 -> devDATAO=16'hA5A5, devBYTEO=1, devWRO=1; byte DATI at odd address with DATAI=16'h5A00 -> kmcNPRDATI=16'h005A.
- Timeout (macro on, TIMEOUT=15): grant given, DONEI never asserted -> NXM set after 15 XFER cycles, DONE pulse, DATI unchanged; next GO clears NXM.
- Race: DONEI asserted on the terminal-count cycle -> data captured, NXM=0.
- GO asserted during XFER with different ADDR -> ignored, devADDRO unchanged; kmcNPRACC during BUSY -> kmcSTALL=1 until the DONE cycle.
- kmcINIT asserted in XFER -> next cycle IDLE, all outputs 0, no DONE pulse; a subsequent GO runs normally.
